// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Format codes, FSM states, LI opcodes and a signed-range helper.
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtLi  = 3'd6,
        FmtBad = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StEmit2
    } state_e;

    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [2:0] F3Addi   = 3'b000;

    // True when v is representable as a w-bit two's-complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
        logic [31:0] hi;
        hi = $signed(v) >>> (w - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Places a byte-valued immediate into its RV32I bit positions and range-checks it.
// Purely combinational; register and function fields are added by the caller.
module inst_encoder_imm_pack
    import inst_encoder_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_ok_o
);

    always_comb begin
        word_o     = '0;
        range_ok_o = 1'b1;
        unique case (fmt_i)
            FmtI: begin
                word_o[31:20] = imm_i[11:0];
                range_ok_o    = fits_signed(imm_i, 12);
            end
            FmtS: begin
                word_o[31:25] = imm_i[11:5];
                word_o[11:7]  = imm_i[4:0];
                range_ok_o    = fits_signed(imm_i, 12);
            end
            FmtB: begin
                word_o[31]    = imm_i[12];
                word_o[30:25] = imm_i[10:5];
                word_o[11:8]  = imm_i[4:1];
                word_o[7]     = imm_i[11];
                range_ok_o    = fits_signed(imm_i, 13) && !imm_i[0];
            end
            FmtU: begin
                word_o[31:12] = imm_i[31:12];
                range_ok_o    = (imm_i[11:0] == 12'h000);
            end
            FmtJ: begin
                word_o[31]    = imm_i[20];
                word_o[30:21] = imm_i[10:1];
                word_o[20]    = imm_i[11];
                word_o[19:12] = imm_i[19:12];
                range_ok_o    = fits_signed(imm_i, 21) && !imm_i[0];
            end
            FmtBad:  range_ok_o = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Field-level RV32I instruction encoder with LI expansion, one-word output buffer
// and a wrapping byte-address counter for instruction-memory preload.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_fmt_i,
    input  logic [6:0]        req_opcode_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_rs1_i,
    input  logic [4:0]        req_rs2_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [6:0]        req_funct7_i,
    input  logic [31:0]       req_imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_inst_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              err_range_o
);

    state_e            state_q;
    logic              out_valid_q;
    logic [31:0]       out_inst_q;
    logic [31:0]       pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;

    fmt_e        fmt;
    logic [31:0] imm_word;
    logic        range_ok;
    logic [31:0] fields;
    logic [31:0] word1;
    logic [31:0] word2;
    logic        two_word;
    logic [19:0] li_hi;
    logic        accept;
    logic        drain;

    assign fmt = fmt_e'(req_fmt_i);

    inst_encoder_imm_pack u_imm_pack (
        .fmt_i      (fmt),
        .imm_i      (req_imm_i),
        .word_o     (imm_word),
        .range_ok_o (range_ok)
    );

    always_comb begin
        fields   = '0;
        word2    = '0;
        two_word = 1'b0;
        // (imm + 0x800) >> 12, rounding so the following ADDI's sign-extension cancels out.
        li_hi    = req_imm_i[31:12] + {19'b0, req_imm_i[11]};
        unique case (fmt)
            FmtR:       fields = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i,
                                  req_opcode_i};
            FmtI:       fields = {12'b0, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
            FmtS, FmtB: fields = {7'b0, req_rs2_i, req_rs1_i, req_funct3_i, 5'b0, req_opcode_i};
            FmtU, FmtJ: fields = {20'b0, req_rd_i, req_opcode_i};
            default:    fields = '0;
        endcase
        word1 = imm_word | fields;
        if (fmt == FmtLi) begin
            if (fits_signed(req_imm_i, 12)) begin
                word1 = {req_imm_i[11:0], 5'd0, F3Addi, req_rd_i, OpcOpImm};
            end else begin
                word1 = {li_hi, req_rd_i, OpcLui};
                if (req_imm_i[11:0] != 12'h000) begin
                    two_word = 1'b1;
                    word2    = {req_imm_i[11:0], req_rd_i, F3Addi, req_rd_i, OpcOpImm};
                end
            end
        end
    end

    assign req_ready_o = !rst_i && ((state_q == StIdle) || ((state_q == StEmit) && out_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign drain       = out_valid_q && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            pend_q      <= '0;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
        end else begin
            err_q <= accept && !range_ok;
            if (drain) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
            unique case (state_q)
                StIdle, StEmit: begin
                    if (accept && range_ok) begin
                        out_valid_q <= 1'b1;
                        out_inst_q  <= word1;
                        pend_q      <= word2;
                        state_q     <= two_word ? StEmit2 : StEmit;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StEmit2: begin
                    if (drain) begin
                        out_inst_q <= pend_q;
                        state_q    <= StEmit;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_inst_o  = out_inst_q;
    assign out_addr_o  = addr_q;
    assign err_range_o = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: formats, range errors, LI expansion, backpressure,
// mid-operation reset, and address wrap on a narrow-address instance.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_fmt;
    logic [6:0]  req_opcode;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [31:0] req_imm;
    logic        out_ready;

    logic        req_ready, out_valid, err_range;
    logic [31:0] out_inst;
    logic [9:0]  out_addr;

    logic        w_req_ready, w_out_valid, w_err_range;
    logic [31:0] w_out_inst;
    logic [3:0]  w_out_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_fmt_i    (req_fmt),
        .req_opcode_i (req_opcode),
        .req_rd_i     (req_rd),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_funct3_i (req_funct3),
        .req_funct7_i (req_funct7),
        .req_imm_i    (req_imm),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_inst_o   (out_inst),
        .out_addr_o   (out_addr),
        .err_range_o  (err_range)
    );

    inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'd0)) dut_w (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (w_req_ready),
        .req_fmt_i    (req_fmt),
        .req_opcode_i (req_opcode),
        .req_rd_i     (req_rd),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_funct3_i (req_funct3),
        .req_funct7_i (req_funct7),
        .req_imm_i    (req_imm),
        .out_valid_o  (w_out_valid),
        .out_ready_i  (out_ready),
        .out_inst_o   (w_out_inst),
        .out_addr_o   (w_out_addr),
        .err_range_o  (w_err_range)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        req_fmt    = fmt;
        req_opcode = op;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_funct7 = f7;
        req_imm    = imm;
        req_valid  = 1'b1;
    endtask

    // Issue one single-word request with out_ready high and check the emitted word.
    task automatic one_word(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] exp_inst, input logic [31:0] exp_addr);
        set_req(fmt, op, rd, rs1, rs2, f3, f7, imm);
        chk({tag, "_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_inst"}, out_inst, exp_inst);
        chk({tag, "_addr"}, out_addr, exp_addr);
        chk({tag, "_noerr"}, err_range, 0);
        step();
        chk({tag, "_drained"}, out_valid, 0);
    endtask

    // Issue a request expected to be rejected by the range check.
    task automatic bad_req(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                           input logic [31:0] imm);
        set_req(fmt, op, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, imm);
        step();
        req_valid = 1'b0;
        chk({tag, "_err"}, err_range, 1);
        chk({tag, "_noword"}, out_valid, 0);
        step();
        chk({tag, "_errpulse"}, err_range, 0);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        set_req(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_addr", out_addr, 32'h0);
        chk("rst_err", err_range, 0);
        chk("rst_ready", req_ready, 0);
        rst       = 1'b0;
        req_valid = 1'b0;
        step();
        chk("rst_req_dropped", out_valid, 0);

        one_word("addi_m1", 3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,
                 32'hFFF3_0293, 32'h0);
        one_word("beq_p8", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,
                 32'h0020_8463, 32'h4);
        bad_req("beq_odd", 3'd3, 7'h63, 32'd3);
        bad_req("fmt7", 3'd7, 7'h13, 32'd0);
        one_word("addi_after_err", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,
                 32'h0050_0093, 32'h8);

        // LI needing LUI+ADDI
        set_req(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        step();
        req_valid = 1'b0;
        chk("li2_lui_inst", out_inst, 32'h1234_6537);
        chk("li2_lui_addr", out_addr, 32'hC);
        chk("li2_ready_low", req_ready, 0);
        step();
        chk("li2_addi_valid", out_valid, 1);
        chk("li2_addi_inst", out_inst, 32'hFFF5_0513);
        chk("li2_addi_addr", out_addr, 32'h10);
        chk("li2_ready_back", req_ready, 1);
        step();
        chk("li2_drained", out_valid, 0);

        one_word("li_lui_only", 3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_5000,
                 32'h0000_5537, 32'h14);

        // Backpressure with the ADDI half of an LI pending
        out_ready = 1'b0;
        set_req(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_inst", out_inst, 32'h1234_6537);
            chk("bp_addr", out_addr, 32'h18);
            chk("bp_ready", req_ready, 0);
            step();
        end
        out_ready = 1'b1;
        chk("bp_release_inst", out_inst, 32'h1234_6537);
        step();
        chk("bp_second_inst", out_inst, 32'hFFF5_0513);
        chk("bp_second_addr", out_addr, 32'h1C);
        step();
        chk("bp_drained", out_valid, 0);

        // Back-to-back single-word requests
        set_req(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        step();
        set_req(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        chk("b2b_first_inst", out_inst, 32'h0010_0113);
        chk("b2b_first_addr", out_addr, 32'h20);
        chk("b2b_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_inst", out_inst, 32'h0020_0193);
        chk("b2b_second_addr", out_addr, 32'h24);
        step();
        chk("b2b_drained", out_valid, 0);

        one_word("sw", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,
                 32'h0020_A423, 32'h28);
        one_word("lui", 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,
                 32'h1234_50B7, 32'h2C);
        bad_req("lui_lowbits", 3'd4, 7'h37, 32'h1234_5001);
        one_word("jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800,
                 32'h0010_00EF, 32'h30);
        bad_req("jal_range", 3'd5, 7'h6F, 32'h0010_0000);
        one_word("sub", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF,
                 32'h4020_81B3, 32'h34);
        one_word("bne_min", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFF_F000,
                 32'h8020_9063, 32'h38);
        bad_req("bne_range", 3'd3, 7'h63, 32'd4096);
        bad_req("addi_range", 3'd1, 7'h13, 32'd2048);
        one_word("addi_min", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,
                 32'h8000_0093, 32'h3C);

        // Reset after the LUI half drains: the ADDI half must be discarded
        set_req(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        step();
        req_valid = 1'b0;
        chk("mr_lui_inst", out_inst, 32'h1234_6537);
        step();
        chk("mr_addi_held", out_inst, 32'hFFF5_0513);
        rst = 1'b1;
        step();
        chk("mr_valid_in_rst", out_valid, 0);
        chk("mr_addr_in_rst", out_addr, 32'h0);
        chk("mr_ready_in_rst", req_ready, 0);
        rst = 1'b0;
        step();
        chk("mr_no_addi", out_valid, 0);
        one_word("mr_next", 3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,
                 32'hFFF3_0293, 32'h0);

        // Address wrap on the 4-bit-address instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [11:0] imm12;
            logic [3:0]  exp_a;
            imm12 = 12'(i);
            exp_a = 4'(i * 4);
            set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            step();
            chk("wrap_valid", w_out_valid, 1);
            chk("wrap_inst", w_out_inst, {imm12, 5'd0, 3'd0, 5'd1, 7'h13});
            chk("wrap_addr", w_out_addr, exp_a);
        end
        req_valid = 1'b0;
        step();
        chk("wrap_drained", w_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder for the AdamRiscv test infrastructure, the inverse of immediate decoding: accepts field-level instruction requests, range-checks and places the immediate, and emits 32-bit RV32I words with their byte addresses for instruction-memory preload.
- Sits between a stimulus/program generator (upstream) and the instruction-memory write port (downstream).
- Expands the LI pseudo-op into LUI+ADDI.
- Buffers one output word under backpressure.

## Interface
- `ADDR_W`, 10: output byte-address width; addresses wrap modulo 2^ADDR_W.
- `BASE_ADDR`, 0: address of the first emitted word after reset; must be 4-aligned.

Ports (`name direction width meaning`):
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_fmt` in 3: format code, R=0, I=1, S=2, B=3, U=4, J=5, LI=6; value 7 is illegal.
- `req_opcode` in 7: opcode; ignored for LI.
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register fields.
- `req_funct3` in 3, `req_funct7` in 7: function fields.
- `req_imm` in 32: signed immediate as a byte value (branch/jump offsets are unscaled).
- `out_valid` out 1: word present.
- `out_ready` in 1: sink accepts the word.
- `out_inst` out 32: encoded word.
- `out_addr` out ADDR_W: byte address of `out_inst`.
- `err_range` out 1: one-cycle pulse; the request was dropped.

## Operation
- **Field placement** is the exact inverse of the core's immediate generator:
  - I: `imm[11:0]` → `[31:20]`.
  - S: `imm[11:5]` → `[31:25]`, `imm[4:0]` → `[11:7]`.
  - B: `imm[12|10:5]` → `[31|30:25]`, `imm[4:1|11]` → `[11:8|7]`.
  - U: `imm[31:12]` → `[31:12]`.
  - J: `imm[20|10:1|11|19:12]` → `[31|30:21|20|19:12]`.
  - R: `funct7`/`rs2`/`rs1`/`funct3`/`rd`/`opcode`, with no immediate.
- **Range rules**, all in 2's complement:
  - I/S: `imm` fits in 12-bit signed.
  - B: fits in 13-bit signed and `imm[0]==0`.
  - J: fits in 21-bit signed and `imm[0]==0`.
  - U: `imm[11:0]==0`.
  - Failure, or `req_fmt==7`: no word is emitted, `err_range` pulses the cycle after accept, and the address does not advance.
- **LI rd, imm**:
  - If `imm` fits 12-bit signed: one word, ADDI rd,x0,imm (opcode 0010011, funct3 0).
  - Otherwise: LUI rd,`(imm+0x800)>>12` (opcode 0110111). That is followed by ADDI rd,rd,`imm[11:0]`, unless `imm[11:0]==0`, in which case LUI only.
- **FSM states**:
  - IDLE: output empty.
  - EMIT: one word held.
  - EMIT2: word held, and a second LI word is pending in an internal register.
- **FSM transitions**:
  - IDLE → EMIT on accept of a valid request, or → IDLE on a range error.
  - EMIT → IDLE on drain with no new accept.
  - EMIT stays in EMIT on simultaneous drain and accept.
  - Accept of a two-word LI enters EMIT2.
  - EMIT2 → EMIT on drain; the pending word moves into the output register the same edge.
- **req_ready**: `!rst && (state==IDLE || (state==EMIT && out_ready))`. It is 0 in EMIT2.
- **Address**: `out_addr` increments by 4 on each `out_valid && out_ready`, and wraps to 0 past 2^ADDR_W−4.

## Timing
- Reset values: `out_valid`=0, `out_inst`=0, `out_addr`=BASE_ADDR, `err_range`=0, state IDLE. `req_ready`=0 while `rst` is high.
- Latency: a request accepted in cycle N gives `out_valid` in N+1. The second LI word appears in the cycle after the first is taken.
- `out_inst`/`out_addr` stay stable while `out_valid && !out_ready`.
- Throughput: one word per cycle with `out_ready` held high, including back-to-back single-word requests.
- `rst` mid-operation: the held and pending words are discarded and the address returns to BASE_ADDR. A request presented in the reset cycle is not accepted.

## Structure
- Format codes (R..LI) and the opcodes for LUI/ADDI go into the shared `define.vh`, next to the existing `ItypeL`/`Stype`/`Btype`/`UtypeL`/`Jtype` macros; no local opcode literals.
- One combinational sub-module, `imm_pack`:
  - Inputs: `fmt`, `imm`.
  - Outputs: 32-bit word with only the immediate bits placed, plus `range_ok`.
- The top level ORs in the register and function fields, and owns the FSM, the output register, the pending register and the address counter.

## Test plan
- I: ADDI x5,x6,−1 (opcode 0x13, `imm`=0xFFFFFFFF) → `out_inst`=0xFFF30293 at `out_addr`=0, one cycle after accept.
- B: BEQ x1,x2,+8 → 0x00208463. BEQ with `imm`=3 → `err_range` pulse, no word, next word still at the same address.
- LI x10,0x12345FFF → 0x12346537 at 0, then 0xFFF50513 at 4. `req_ready` is low until the second word drains. LI x10,0x5000 → only 0x00005537.
- Backpressure: `out_ready` low for 5 cycles with LI pending → `out_inst`/`out_addr` constant, `req_ready`=0, no word lost or duplicated.
- Wrap: ADDR_W=4, six ADDI requests with `out_ready`=1 → addresses 0,4,8,C,0,4.
- Reset after the LUI word drains but before the ADDI → ADDI never appears; the next request emits at BASE_ADDR, and `out_valid` is 0 during reset.
